// File: rtl/alu_pkg.sv
// Shared widths and payload types for the pipelined subtractor.
package alu_pkg;

    localparam int unsigned SUB_W    = 32;
    localparam int unsigned SUB_HALF = 16;
    localparam int unsigned CS_BLK   = 4;

    typedef struct packed {
        logic overflow;
        logic not_equal;
        logic less_than;
        logic borrow;
    } sub_flags_t;

    // Everything stage 2 needs to finish the upper half and derive the flags.
    typedef struct packed {
        logic [SUB_HALF-1:0] lo;
        logic                c16;
        logic [SUB_HALF-1:0] a_hi;
        logic [SUB_HALF-1:0] nb_hi;
        logic                a_msb;
        logic                b_msb;
    } s1_payload_t;

    function automatic sub_flags_t calc_flags(
        input logic [SUB_W-1:0] res,
        input logic             c32,
        input logic             a_msb,
        input logic             b_msb
    );
        sub_flags_t f;
        f.overflow  = (a_msb != b_msb) && (res[SUB_W-1] != a_msb);
        f.less_than = res[SUB_W-1] ^ f.overflow;
        f.not_equal = |res;
        f.borrow    = ~c32;
        return f;
    endfunction

endpackage

// File: rtl/add_16bit_slice.sv
// 16-bit carry-select adder: 4-bit blocks precompute both carry-in cases.
module add_16bit_slice
    import alu_pkg::*;
(
    input  logic [SUB_HALF-1:0] a,
    input  logic [SUB_HALF-1:0] b,
    input  logic                cin,
    output logic [SUB_HALF-1:0] sum,
    output logic                cout
);

    localparam int unsigned NBLK = SUB_HALF / CS_BLK;
    localparam int unsigned BW   = CS_BLK + 1;

    logic [BW-1:0] sum0 [NBLK];
    logic [BW-1:0] sum1 [NBLK];

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        assign sum0[i] = BW'(a[i*CS_BLK +: CS_BLK]) + BW'(b[i*CS_BLK +: CS_BLK]);
        assign sum1[i] = sum0[i] + BW'(1);
    end

    logic [BW-1:0] sel;
    logic          carry;

    // Block carries ripple only through the select muxes.
    always_comb begin
        sum   = '0;
        sel   = '0;
        carry = cin;
        for (int i = 0; i < NBLK; i++) begin
            sel                     = carry ? sum1[i] : sum0[i];
            sum[i*CS_BLK +: CS_BLK] = sel[CS_BLK-1:0];
            carry                   = sel[CS_BLK];
        end
        cout = carry;
    end

endmodule

// File: rtl/pipe_sub_32bit.sv
// Two-stage A - B (as A + ~B + 1): low half in stage 1, high half and flags in stage 2,
// with valid/ready on both sides.
module pipe_sub_32bit
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUB_W-1:0] data_operandA,
    input  logic [SUB_W-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUB_W-1:0] data_result,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             borrow
);

    logic        s1_valid;
    logic        s2_valid;
    s1_payload_t s1_q;
    s1_payload_t s1_d;
    sub_flags_t  s2_flags;
    sub_flags_t  flags_d;

    logic [SUB_W-1:0]    nb;
    logic [SUB_HALF-1:0] lo_sum;
    logic [SUB_HALF-1:0] hi_sum;
    logic                c16;
    logic                c32;
    logic [SUB_W-1:0]    diff;

    logic s2_load;
    logic in_xfer;

    assign nb = ~data_operandB;

    add_16bit_slice u_lo (
        .a    (data_operandA[SUB_HALF-1:0]),
        .b    (nb[SUB_HALF-1:0]),
        .cin  (1'b1),
        .sum  (lo_sum),
        .cout (c16)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.lo    = lo_sum;
        s1_d.c16   = c16;
        s1_d.a_hi  = data_operandA[SUB_W-1:SUB_HALF];
        s1_d.nb_hi = nb[SUB_W-1:SUB_HALF];
        s1_d.a_msb = data_operandA[SUB_W-1];
        s1_d.b_msb = data_operandB[SUB_W-1];
    end

    add_16bit_slice u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.nb_hi),
        .cin  (s1_q.c16),
        .sum  (hi_sum),
        .cout (c32)
    );

    assign diff    = {hi_sum, s1_q.lo};
    assign flags_d = calc_flags(diff, c32, s1_q.a_msb, s1_q.b_msb);

    // Stage 2 refills in the same cycle it drains, so a full pipe never bubbles.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid    <= 1'b0;
            data_result <= '0;
            s2_flags    <= '0;
        end else begin
            if (s2_load) begin
                s2_valid    <= 1'b1;
                data_result <= diff;
                s2_flags    <= flags_d;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign overflow   = s2_flags.overflow;
    assign isNotEqual = s2_flags.not_equal;
    assign isLessThan = s2_flags.less_than;
    assign borrow     = s2_flags.borrow;

endmodule

// File: doc/pipe_sub_32bit.md
# pipe_sub_32bit

Two-stage pipelined 32-bit two's-complement subtractor with valid/ready handshakes on both sides. It computes A − B as A + ~B + 1, with the low 16 bits in stage 1 and the high 16 bits in stage 2. It produces the difference plus overflow, not-equal, less-than and borrow flags. It sits beside the combinational carry-select adder path in the ALU and serves multi-cycle compare/subtract operations that need a registered, back-pressurable result.

## Interface
Parameters:
- none; width fixed at 32 (constant `SUB_W` = 32, `SUB_HALF` = 16 in package)

Ports:
- `clock`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block accepts operands this cycle
- `data_operandA`  in  32  minuend
- `data_operandB`  in  32  subtrahend
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result this cycle
- `data_result`  out  32  A − B, mod 2^32
- `overflow`  out  1  signed overflow
- `isNotEqual`  out  1  A ≠ B
- `isLessThan`  out  1  signed A < B
- `borrow`  out  1  unsigned A < B

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1) captures on input transfer:
  - low sum = A[15:0] + ~B[15:0] + 1, giving 16 bits plus carry c16
  - A[31:16], ~B[31:16], and A[31], B[31] for the flags
- Stage 2 (S2) captures on S1 advance:
  - high sum = A[31:16] + ~B[31:16] + c16, giving 16 bits plus carry c32
  - concatenated result
  - flags computed from the full 32-bit result:
    - `overflow` = (A[31] ≠ B[31]) && (result[31] ≠ A[31])
    - `isLessThan` = result[31] XOR overflow
    - `isNotEqual` = |result
    - `borrow` = ~c32
- Flags are registered in S2 with `data_result`; all of them are valid only when `out_valid`=1.
- S2 loads when S1 is valid and (S2 is empty or S2 is transferring out this cycle).
- `in_ready` = !s1_valid || s1_advance. A full pipe accepts a new operand in the same cycle both stages drain; there is no bubble.
- Backpressure: with `out_ready`=0 and both stages full, `in_ready`=0 and all registers hold. Held outputs must not change while `out_valid`=1 and `out_ready`=0.
- Operand inputs are don't-care when `in_valid`=0. Captured operands are independent of later input changes.
- No reordering or dropping; results leave in acceptance order.
- Wrap-around: result is modulo 2^32. 0x00000000 − 0x00000001 = 0xFFFFFFFF, with borrow=1 and overflow=0.

## Timing
- Reset (`resetn`=0, asynchronous):
  - s1_valid=0 and s2_valid=0
  - `out_valid`=0, `in_ready`=1
  - `data_result`=0, all flags 0
- Reset mid-operation discards all in-flight operands. The first cycle after deassertion behaves as empty.
- Latency: operands accepted on edge N give `out_valid`=1 after edge N+1, i.e. 2 edges from acceptance to visible result.
- Throughput: one result per cycle while `out_ready`=1.
- Simultaneous input and output transfer with both stages full: S2 takes the S1 contents, S1 takes the new operands, occupancy stays 2.
- Outputs are driven only from registers; no combinational path from operand inputs to outputs. `in_ready` depends combinationally on `out_ready`.

## Structure
- Package `alu_pkg`: `SUB_W`, `SUB_HALF`, and a packed typedef for the flag bundle (overflow, isNotEqual, isLessThan, borrow).
- Sub-module `add_16bit_slice`: combinational 16-bit add with cin and cout. Instantiated twice, once per stage. Internals are free (carry-select permitted).
- Top module holds the two stage registers, valid bits and handshake logic.

## Test plan
- Basic: A=0x0000000A, B=0x00000003 → result 0x00000007, isNotEqual=1, isLessThan=0, borrow=0, overflow=0, 2 edges after accept.
- Cross-half borrow: A=0x00010000, B=0x00000001 → 0x0000FFFF, borrow=0. Then A=0, B=1 → 0xFFFFFFFF, borrow=1, isLessThan=1, overflow=0.
- Overflow: A=0x80000000, B=0x00000001 → 0x7FFFFFFF, overflow=1, isLessThan=1. Also A=0x7FFFFFFF, B=0xFFFFFFFF → 0x80000000, overflow=1, isLessThan=0.
- Equal: A=B=0x12345678 → result 0, isNotEqual=0, isLessThan=0, borrow=0.
- Backpressure: stream 5 operand pairs with `out_ready`=0 for 4 cycles.
  - `in_ready` drops after 2 accepts.
  - Outputs are stable while stalled.
  - All 5 results appear in order once released.
  - Full-rate streaming shows one result per cycle.
- Reset mid-flight: accept 2 pairs, assert `resetn`=0 between edges.
  - `out_valid`=0, `in_ready`=1 immediately.
  - No stale result appears after release.
